universal_shift_register: RTL and testbench



---
 rtl/mac_pkg.sv | 27 ++
 rtl/shift_counter.sv | 47 ++++
 rtl/universal_shift_register.sv | 157 +++++++++++++++
 tb/tb_universal_shift_register.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared MODE and FSM state encodings for the MAC shift register
//
// Purpose: operation-select and multi-shift FSM encodings shared by the
//          universal shift register and anything that drives its MODE input.
// Contents:
//   mode_e  - 3-bit MODE decode (hold, load, clear, set, shl, shr, rol, mshift)
//   state_e - multi-shift FSM states (IDLE, SHIFT, FIN)
package mac_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD   = 3'b000,
    MODE_LOAD   = 3'b001,
    MODE_CLEAR  = 3'b010,
    MODE_SET    = 3'b011,
    MODE_SHL    = 3'b100,
    MODE_SHR    = 3'b101,
    MODE_ROL    = 3'b110,
    MODE_MSHIFT = 3'b111
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_FIN   = 2'b10
  } state_e;

endpackage

// File: rtl/shift_counter.sv
// rtl/shift_counter.sv - loadable down-counter with zero and last-step flags
//
// Purpose: counts the remaining positions of a multi-shift.
// Ports:
//   clk_i       - rising-edge clock
//   rst_ni      - asynchronous active-low reset (count -> 0)
//   load_i      - load load_val_i (has priority over dec_i)
//   load_val_i  - value to load
//   dec_i       - decrement by one; saturates at zero
//   zero_o      - count is zero
//   last_o      - count is one (the next decrement is the final step)
module shift_counter #(
  parameter int CW = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          dec_i,
  output logic          zero_o,
  output logic          last_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);
  assign last_o = (cnt_q == CW'(1));

endmodule

// File: rtl/universal_shift_register.sv
// rtl/universal_shift_register.sv - N-bit universal shift register with multi-shift FSM
//
// Purpose: shift/alignment register for the MAC datapath. Hold, load, clear,
//          set, single-step shift left/right, rotate left, and a multi-cycle
//          shift-by-N with BUSY/DONE handshake.
// Ports:
//   CLK     - rising-edge clock
//   RST_N   - asynchronous active-low reset
//   MODE    - operation select (mac_pkg::mode_e)
//   START   - launches multi-shift when MODE=MSHIFT and idle
//   DIR     - multi-shift direction: 0 = left, 1 = right
//   CNT     - multi-shift distance, saturated to WIDTH
//   D       - parallel load data
//   SIN_L   - serial in at MSB for single-step right shift
//   SIN_R   - serial in at LSB for single-step left shift
//   Q       - register contents
//   SOUT_L  - Q[WIDTH-1]
//   SOUT_R  - Q[0]
//   BUSY    - multi-shift in progress
//   DONE    - one-cycle pulse after the last multi-shift step
module universal_shift_register
  import mac_pkg::*;
#(
  parameter int  WIDTH       = 8,
  parameter bit  ARITH_RIGHT = 1'b1,
  localparam int CW          = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [2:0]       MODE,
  input  logic             START,
  input  logic             DIR,
  input  logic [CW-1:0]    CNT,
  input  logic [WIDTH-1:0] D,
  input  logic             SIN_L,
  input  logic             SIN_R,
  output logic [WIDTH-1:0] Q,
  output logic             SOUT_L,
  output logic             SOUT_R,
  output logic             BUSY,
  output logic             DONE
);

  logic [WIDTH-1:0] q_q, q_d;
  state_e           state_q, state_d;
  logic             dir_q, dir_d;

  mode_e            mode;
  logic [CW-1:0]    n_sat;
  logic             fill_r;
  logic [WIDTH-1:0] mshift_q;

  logic             ctr_load;
  logic [CW-1:0]    ctr_val;
  logic             ctr_dec;
  logic             ctr_zero;
  logic             ctr_last;

  assign mode = mode_e'(MODE);

  // Distances beyond the register width all give the same all-fill result.
  assign n_sat = (CNT > CW'(WIDTH)) ? CW'(WIDTH) : CNT;

  assign fill_r   = ARITH_RIGHT ? q_q[WIDTH-1] : 1'b0;
  assign mshift_q = dir_q ? {fill_r, q_q[WIDTH-1:1]} : {q_q[WIDTH-2:0], 1'b0};

  shift_counter #(
    .CW(CW)
  ) u_shift_counter (
    .clk_i      (CLK),
    .rst_ni     (RST_N),
    .load_i     (ctr_load),
    .load_val_i (ctr_val),
    .dec_i      (ctr_dec),
    .zero_o     (ctr_zero),
    .last_o     (ctr_last)
  );

  always_comb begin
    q_d      = q_q;
    state_d  = state_q;
    dir_d    = dir_q;
    ctr_load = 1'b0;
    ctr_val  = '0;
    ctr_dec  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        unique case (mode)
          MODE_HOLD:  q_d = q_q;
          MODE_LOAD:  q_d = D;
          MODE_CLEAR: q_d = '0;
          MODE_SET:   q_d = '1;
          MODE_SHL:   q_d = {q_q[WIDTH-2:0], SIN_R};
          MODE_SHR:   q_d = {SIN_L, q_q[WIDTH-1:1]};
          MODE_ROL:   q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          MODE_MSHIFT: begin
            if (START) begin
              dir_d    = DIR;
              ctr_load = 1'b1;
              ctr_val  = n_sat;
              // A zero-length shift still completes through FIN so the
              // requester always sees exactly one DONE pulse.
              state_d  = (n_sat == '0) ? ST_FIN : ST_SHIFT;
            end
          end
          default: q_d = q_q;
        endcase
      end

      ST_SHIFT: begin
        if (mode == MODE_CLEAR) begin
          // Abort: clear, drop straight back to IDLE, no DONE.
          q_d      = '0;
          state_d  = ST_IDLE;
          ctr_load = 1'b1;
          ctr_val  = '0;
        end else begin
          q_d     = mshift_q;
          ctr_dec = 1'b1;
          // ctr_zero cannot normally be seen here; it keeps the FSM from
          // sticking in SHIFT if the counter is ever found empty.
          if (ctr_last || ctr_zero) begin
            state_d = ST_FIN;
          end
        end
      end

      ST_FIN: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      q_q     <= '0;
      state_q <= ST_IDLE;
      dir_q   <= 1'b0;
    end else begin
      q_q     <= q_d;
      state_q <= state_d;
      dir_q   <= dir_d;
    end
  end

  assign Q      = q_q;
  assign SOUT_L = q_q[WIDTH-1];
  assign SOUT_R = q_q[0];
  assign BUSY   = (state_q == ST_SHIFT);
  assign DONE   = (state_q == ST_FIN);

endmodule

// File: tb/tb_universal_shift_register.sv
// tb/tb_universal_shift_register.sv - scoreboard bench for universal_shift_register
module tb_universal_shift_register;
  import mac_pkg::*;

  localparam int W  = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic [2:0]    mode  = 3'b000;
  logic          start = 1'b0;
  logic          dir   = 1'b0;
  logic [CW-1:0] cnt   = '0;
  logic [W-1:0]  d     = '0;
  logic          sin_l = 1'b0;
  logic          sin_r = 1'b0;

  logic [W-1:0] q_a, q_l;
  logic sl_a, sr_a, busy_a, done_a;
  logic sl_l, sr_l, busy_l, done_l;

  universal_shift_register #(.WIDTH(W), .ARITH_RIGHT(1'b1)) dut_a (
    .CLK(clk), .RST_N(rst_n), .MODE(mode), .START(start), .DIR(dir), .CNT(cnt),
    .D(d), .SIN_L(sin_l), .SIN_R(sin_r), .Q(q_a), .SOUT_L(sl_a), .SOUT_R(sr_a),
    .BUSY(busy_a), .DONE(done_a)
  );

  universal_shift_register #(.WIDTH(W), .ARITH_RIGHT(1'b0)) dut_l (
    .CLK(clk), .RST_N(rst_n), .MODE(mode), .START(start), .DIR(dir), .CNT(cnt),
    .D(d), .SIN_L(sin_l), .SIN_R(sin_r), .Q(q_l), .SOUT_L(sl_l), .SOUT_R(sr_l),
    .BUSY(busy_l), .DONE(done_l)
  );

  typedef struct {
    logic         chk;
    logic [W-1:0] qa;
    logic [W-1:0] ql;
    logic         busy;
    logic         done;
    string        tag;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check_dut(input string tag, input string who, input logic chk,
                           input logic [W-1:0] eq, input logic [W-1:0] aq,
                           input logic asl, input logic asr,
                           input logic eb, input logic ab,
                           input logic ed, input logic ad);
    if (chk && (aq !== eq || asl !== eq[W-1] || asr !== eq[0])) begin
      miscompares++;
      $display("FAIL %s/%s q: got %h sout_l=%b sout_r=%b, want %h sout_l=%b sout_r=%b",
               tag, who, aq, asl, asr, eq, eq[W-1], eq[0]);
    end
    if (ab !== eb || ad !== ed) begin
      miscompares++;
      $display("FAIL %s/%s handshake: got busy=%b done=%b, want busy=%b done=%b",
               tag, who, ab, ad, eb, ed);
    end
  endtask

  // Monitor: the DUT presents a new state after every clock edge and after
  // an asynchronous reset; each one consumes the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or negedge rst_n);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        check_dut(e.tag, "arith", e.chk, e.qa, q_a, sl_a, sr_a, e.busy, busy_a, e.done, done_a);
        check_dut(e.tag, "logic", e.chk, e.ql, q_l, sl_l, sr_l, e.busy, busy_l, e.done, done_l);
      end
    end
  end

  // Drive one cycle of inputs and queue the state expected after the next edge.
  task automatic step(input logic r, input logic [2:0] m, input logic st, input logic dr,
                      input logic [CW-1:0] c, input logic [W-1:0] dd,
                      input logic sl, input logic sr, input logic chk,
                      input logic [W-1:0] qa, input logic [W-1:0] ql,
                      input logic b, input logic dn, input string tag);
    @(negedge clk);
    #2;
    rst_n = r; mode = m; start = st; dir = dr; cnt = c; d = dd; sin_l = sl; sin_r = sr;
    sb.push_back('{chk, qa, ql, b, dn, tag});
  endtask

  task automatic ss(input logic [2:0] m, input logic [W-1:0] dd, input logic sl,
                    input logic sr, input logic [W-1:0] q, input string tag);
    step(1'b1, m, 1'b0, 1'b0, '0, dd, sl, sr, 1'b1, q, q, 1'b0, 1'b0, tag);
  endtask

  task automatic hold(input logic [W-1:0] qa, input logic [W-1:0] ql,
                      input logic b, input logic dn, input string tag);
    step(1'b1, MODE_HOLD, 1'b0, 1'b0, '0, 8'h00, 1'b0, 1'b0, 1'b1, qa, ql, b, dn, tag);
  endtask

  task automatic launch(input logic dr, input logic [CW-1:0] c, input logic [W-1:0] q,
                        input logic b, input logic dn, input string tag);
    step(1'b1, MODE_MSHIFT, 1'b1, dr, c, 8'h00, 1'b0, 1'b0, 1'b1, q, q, b, dn, tag);
  endtask

  initial begin
    logic [W-1:0] walk [7];
    walk = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

    step(1'b0, MODE_HOLD, 1'b0, 1'b0, '0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, "reset0");
    step(1'b0, MODE_LOAD, 1'b1, 1'b0, '0, 8'hFF, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, "reset1");

    ss(MODE_LOAD,  8'hA5, 1'b0, 1'b0, 8'hA5, "load_a5");
    ss(MODE_ROL,   8'h00, 1'b0, 1'b0, 8'h4B, "rol");
    ss(MODE_SHL,   8'h00, 1'b0, 1'b1, 8'h97, "shl_sin1");
    ss(MODE_SHR,   8'h00, 1'b0, 1'b0, 8'h4B, "shr_sin0");
    ss(MODE_SHR,   8'h00, 1'b1, 1'b0, 8'hA5, "shr_sin1");
    ss(MODE_SET,   8'h00, 1'b0, 1'b0, 8'hFF, "set");
    ss(MODE_CLEAR, 8'h00, 1'b0, 1'b0, 8'h00, "clear");
    ss(MODE_HOLD,  8'h5A, 1'b1, 1'b1, 8'h00, "hold");

    ss(MODE_LOAD, 8'h80, 1'b0, 1'b0, 8'h80, "load_80");
    launch(1'b1, 4'd3, 8'h80, 1'b1, 1'b0, "sr3_launch");
    hold(8'hC0, 8'h40, 1'b1, 1'b0, "sr3_s1");
    hold(8'hE0, 8'h20, 1'b1, 1'b0, "sr3_s2");
    hold(8'hF0, 8'h10, 1'b0, 1'b1, "sr3_fin");
    hold(8'hF0, 8'h10, 1'b0, 1'b0, "sr3_idle");

    ss(MODE_LOAD, 8'h81, 1'b0, 1'b0, 8'h81, "load_81");
    launch(1'b0, 4'd12, 8'h81, 1'b1, 1'b0, "sl12_launch");
    for (int i = 0; i < 7; i++) begin
      step(1'b1, MODE_LOAD, i[0], 1'b1, 4'd1, 8'hFF, 1'b1, 1'b1, 1'b1,
           walk[i], walk[i], 1'b1, 1'b0, "sl12_busy");
    end
    step(1'b1, MODE_LOAD, 1'b1, 1'b1, 4'd1, 8'hFF, 1'b1, 1'b1, 1'b1,
         8'h00, 8'h00, 1'b0, 1'b1, "sl12_fin");
    step(1'b1, MODE_MSHIFT, 1'b1, 1'b0, 4'd3, 8'hFF, 1'b0, 1'b0, 1'b1,
         8'h00, 8'h00, 1'b0, 1'b0, "start_in_fin");
    hold(8'h00, 8'h00, 1'b0, 1'b0, "sl12_idle");

    ss(MODE_LOAD, 8'h3C, 1'b0, 1'b0, 8'h3C, "load_3c");
    launch(1'b0, 4'd0, 8'h3C, 1'b0, 1'b1, "cnt0_fin");
    hold(8'h3C, 8'h3C, 1'b0, 1'b0, "cnt0_idle");

    ss(MODE_LOAD, 8'hA0, 1'b0, 1'b0, 8'hA0, "load_a0");
    launch(1'b0, 4'd5, 8'hA0, 1'b1, 1'b0, "abort_launch");
    hold(8'h40, 8'h40, 1'b1, 1'b0, "abort_s1");
    hold(8'h80, 8'h80, 1'b1, 1'b0, "abort_s2");
    step(1'b1, MODE_CLEAR, 1'b0, 1'b0, '0, 8'h00, 1'b0, 1'b0, 1'b1,
         8'h00, 8'h00, 1'b0, 1'b0, "abort_clear");
    hold(8'h00, 8'h00, 1'b0, 1'b0, "abort_nodone0");
    hold(8'h00, 8'h00, 1'b0, 1'b0, "abort_nodone1");

    ss(MODE_LOAD, 8'h0F, 1'b0, 1'b0, 8'h0F, "load_0f");
    launch(1'b1, 4'd5, 8'h0F, 1'b1, 1'b0, "arst_launch");
    hold(8'h07, 8'h07, 1'b1, 1'b0, "arst_s1");
    @(negedge clk);
    #2;
    sb.push_back('{1'b1, 8'h00, 8'h00, 1'b0, 1'b0, "arst_async"});
    rst_n = 1'b0;
    step(1'b0, MODE_HOLD, 1'b0, 1'b0, '0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, "arst_held");
    hold(8'h00, 8'h00, 1'b0, 1'b0, "arst_release");

    ss(MODE_LOAD, 8'h01, 1'b0, 1'b0, 8'h01, "load_01");
    launch(1'b0, 4'd1, 8'h01, 1'b1, 1'b0, "sl1_launch");
    hold(8'h02, 8'h02, 1'b0, 1'b1, "sl1_fin");
    hold(8'h02, 8'h02, 1'b0, 1'b0, "sl1_idle");

    repeat (2) @(negedge clk);
    #3;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
